// File: rtl/enigma_pkg.sv
// Shared types, wiring tables and mod-26 helpers for the Enigma scrambler.
// Tables are ASCII strings; entry 0 is the leftmost character.
package enigma_pkg;

    localparam int ALPHA  = 26;
    localparam int NTYPES = 5;

    typedef logic [4:0] letter_t;

    typedef enum logic [2:0] {
        ROT_I   = 3'd0,
        ROT_II  = 3'd1,
        ROT_III = 3'd2,
        ROT_IV  = 3'd3,
        ROT_V   = 3'd4
    } rotor_type_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } map_dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_FWD,
        S_REFL,
        S_BWD,
        S_OUT
    } state_t;

    localparam logic [207:0] FWD_TBL [NTYPES] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK"
    };

    localparam logic [207:0] INV_TBL [NTYPES] = '{
        "UWYGADFPVZBECKMTHXSLRINQOJ",
        "AJPCZWRLFBDKOTYUQGENHXMIVS",
        "TAGBPCSDQEUFVNZHYIXJWLRKOM",
        "HZWVARTNLGUPXQCEJMBSKDYOIF",
        "QCYLXWENFTZOSMVJUDKGIARPHB"
    };

    localparam logic [207:0] REFL_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    localparam letter_t NOTCH [NTYPES] = '{
        5'd16, 5'd4, 5'd21, 5'd9, 5'd25
    };

    function automatic letter_t tbl_get(
        input logic [207:0] tbl,
        input letter_t      i
    );
        logic [7:0] ch;
        ch = 8'(tbl >> (8 * (25 - int'(i))));
        return letter_t'(ch - 8'd65);
    endfunction

    function automatic letter_t add26(input letter_t a, input letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic letter_t sub26(input letter_t a, input letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic letter_t refl_b(input letter_t c);
        return tbl_get(REFL_B, c);
    endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor pass: offset by position, look up wiring, remove offset.
// Direction selects the forward or inverse wiring table.
module enigma_rotor_map
    import enigma_pkg::*;
(
    input  letter_t     letter,
    input  letter_t     pos,
    input  rotor_type_t rtype,
    input  map_dir_t    dir,
    output letter_t     result
);

    letter_t idx;
    letter_t wired;

    // Shift into rotor frame, translate, shift back out
    always_comb begin
        idx = add26(letter, pos);
        if (dir == DIR_FWD) wired = tbl_get(FWD_TBL[rtype], idx);
        else                wired = tbl_get(INV_TBL[rtype], idx);
        result = sub26(wired, pos);
    end

endmodule

// File: rtl/enigma_rotor_pipe.sv
// Multi-cycle Enigma core: one shared rotor-map unit walks
// forward, reflector, then backward, one pass per clock.
module enigma_rotor_pipe
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int LW         = 5,
    parameter int ALPHA      = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_letter,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_letter,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_idx,
    input  logic [2:0]    cfg_type,
    input  logic [LW-1:0] cfg_pos,
    output logic          busy
);

    localparam logic [2:0] KLAST = 3'(NUM_ROTORS - 1);

    state_t      state, state_nx;
    logic [2:0]  k;
    letter_t     cur, out_q;
    logic        byp;
    letter_t     pos [NUM_ROTORS];
    rotor_type_t typ [NUM_ROTORS];

    logic [NUM_ROTORS-1:0] at_notch, stp;
    logic        cfg_ok, cfg_hit, accept;
    letter_t     sel_pos, map_in, map_out;
    rotor_type_t sel_typ;
    map_dir_t    map_dir;

    assign cfg_ok = (32'(cfg_idx) < NUM_ROTORS)
                 && (cfg_type <= 3'd4)
                 && (32'(cfg_pos) < ALPHA);
    assign cfg_hit   = cfg_we && cfg_ok && (state == S_IDLE);
    assign in_ready  = (state == S_IDLE) && !rst && !cfg_hit;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_OUT);
    assign out_letter = out_q;
    assign busy      = (state != S_IDLE);

    // Stepping decisions from pre-step positions; middle rotors double-step
    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_step
        assign at_notch[g] = (pos[g] == NOTCH[typ[g]]);
        if (g == 0) begin : g_first
            assign stp[g] = 1'b1;
        end else if (g <= NUM_ROTORS - 2) begin : g_mid
            assign stp[g] = at_notch[g-1] | at_notch[g];
        end else begin : g_last
            assign stp[g] = at_notch[g-1];
        end
    end

    // Pick the rotor currently addressed by the pass counter
    always_comb begin
        sel_pos = pos[0];
        sel_typ = typ[0];
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (k == 3'(i)) begin
                sel_pos = pos[i];
                sel_typ = typ[i];
            end
        end
        map_in  = byp ? '0 : cur;
        map_dir = (state == S_BWD) ? DIR_BWD : DIR_FWD;
    end

    enigma_rotor_map u_map (
        .letter (map_in),
        .pos    (sel_pos),
        .rtype  (sel_typ),
        .dir    (map_dir),
        .result (map_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state sequencing through the rotor passes
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = S_STEP;
            S_STEP: state_nx = S_FWD;
            S_FWD:  if (k == KLAST) state_nx = S_REFL;
            S_REFL: state_nx = S_BWD;
            S_BWD:  if (k == 3'd0) state_nx = S_OUT;
            S_OUT:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: config, rotor stepping, letter transform, result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= '0;
            out_q <= '0;
            byp   <= 1'b0;
            k     <= '0;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos[i] <= '0;
                typ[i] <= (i == 0) ? ROT_III : (i == 1) ? ROT_II : ROT_I;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_hit) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            if (cfg_idx == 3'(i)) begin
                                pos[i] <= cfg_pos;
                                typ[i] <= rotor_type_t'(cfg_type);
                            end
                        end
                    end else if (accept) begin
                        cur <= in_letter;
                        byp <= (32'(in_letter) >= ALPHA);
                    end
                end
                S_STEP: begin
                    k <= '0;
                    if (!byp) begin
                        for (int i = 0; i < NUM_ROTORS; i++) begin
                            if (stp[i]) pos[i] <= add26(pos[i], 5'd1);
                        end
                    end
                end
                S_FWD: begin
                    if (!byp) cur <= map_out;
                    if (k != KLAST) k <= k + 3'd1;
                end
                S_REFL: begin
                    if (!byp) cur <= refl_b(cur);
                    k <= KLAST;
                end
                S_BWD: begin
                    if (!byp) cur <= map_out;
                    if (k == 3'd0) out_q <= byp ? cur : map_out;
                    else           k <= k - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_rotor_pipe.sv
// Self-checking bench for enigma_rotor_pipe against a string-table
// Enigma model using plain modular arithmetic.
module tb_enigma_rotor_pipe;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [4:0] in_letter;
    logic       out_valid, out_ready;
    logic [4:0] out_letter;
    logic       cfg_we;
    logic [2:0] cfg_idx, cfg_type;
    logic [4:0] cfg_pos;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    int    mpos [N];
    int    mtyp [N];
    string WIR [5];
    string REFB;
    int    MNOTCH [5];

    enigma_rotor_pipe #(.NUM_ROTORS(N), .LW(5), .ALPHA(26)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_letter  (in_letter),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_type   (cfg_type),
        .cfg_pos    (cfg_pos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int m_fwd(int t, int c, int p);
        int x;
        x = (c + p) % 26;
        return (int'(WIR[t][x]) - 65 - p + 26) % 26;
    endfunction

    function automatic int m_bwd(int t, int c, int p);
        int x;
        x = (c + p) % 26;
        for (int j = 0; j < 26; j++)
            if (int'(WIR[t][j]) - 65 == x) return (j - p + 26) % 26;
        return 0;
    endfunction

    function automatic void m_step();
        int  old [N];
        bit  mv;
        for (int i = 0; i < N; i++) old[i] = mpos[i];
        for (int i = 0; i < N; i++) begin
            if (i == 0) mv = 1;
            else begin
                mv = (old[i-1] == MNOTCH[mtyp[i-1]]);
                if (i <= N - 2 && old[i] == MNOTCH[mtyp[i]]) mv = 1;
            end
            if (mv) mpos[i] = (old[i] + 1) % 26;
        end
    endfunction

    function automatic int m_encrypt(int l);
        int c;
        if (l >= 26) return l;
        m_step();
        c = l;
        for (int i = 0; i < N; i++) c = m_fwd(mtyp[i], c, mpos[i]);
        c = int'(REFB[c]) - 65;
        for (int i = N - 1; i >= 0; i--) c = m_bwd(mtyp[i], c, mpos[i]);
        return c;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            mpos[i] = 0;
            mtyp[i] = (i == 0) ? 2 : (i == 1) ? 1 : 0;
        end
    endfunction

    task automatic apply_reset();
        rst = 1; in_valid = 0; out_ready = 0; cfg_we = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        m_reset();
    endtask

    task automatic do_cfg(input int idx, input int ty, input int p);
        int n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        cfg_we = 1; cfg_idx = 3'(idx); cfg_type = 3'(ty); cfg_pos = 5'(p);
        @(posedge clk); #1;
        cfg_we = 0;
        if (idx < N && ty <= 4 && p < 26) begin
            mpos[idx] = p;
            mtyp[idx] = ty;
        end
    endtask

    task automatic encrypt(input int l, input int stall,
                           output int got, output int lat);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_ready_wait: got %b want 1", in_ready);
        end
        in_valid = 1; in_letter = 5'(l);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        got = int'(out_letter);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0; cfg_we = 0;
        in_letter = 0; cfg_idx = 0; cfg_type = 0; cfg_pos = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (out_letter !== 5'd0) begin
            fails++; $display("FAIL rst_out_letter: got %0d want 0", out_letter);
        end
        rst = 0;
        m_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_known_vector();
        string e;
        int got, lat, ex;
        e = "BDZGO";
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            ex = m_encrypt(0);
            encrypt(0, 0, got, lat);
            checks++;
            if (got !== int'(e[i]) - 65) begin
                fails++;
                $display("FAIL aaaaa_%0d: got %0d want %0d", i, got, int'(e[i]) - 65);
            end
            checks++;
            if (lat !== 8) begin
                fails++; $display("FAIL latency_%0d: got %0d want 8", i, lat);
            end
        end
    endtask

    task automatic test_double_step();
        int e0 [3], e1 [3], e2 [3];
        int got, lat, ex, l;
        e0 = '{21, 22, 23};
        e1 = '{3, 4, 5};
        e2 = '{0, 0, 1};
        apply_reset();
        do_cfg(0, 2, 20);
        do_cfg(1, 1, 3);
        do_cfg(2, 0, 0);
        for (int s = 0; s < 3; s++) begin
            l = $urandom_range(0, 25);
            ex = m_encrypt(l);
            encrypt(l, 0, got, lat);
            checks++;
            if (int'(dut.pos[0]) !== e0[s] || int'(dut.pos[1]) !== e1[s]
                || int'(dut.pos[2]) !== e2[s]) begin
                fails++;
                $display("FAIL dstep_pos_%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         s, dut.pos[2], dut.pos[1], dut.pos[0],
                         e2[s], e1[s], e0[s]);
            end
            checks++;
            if (got !== ex) begin
                fails++; $display("FAIL dstep_ct_%0d: got %0d want %0d", s, got, ex);
            end
        end
    endtask

    task automatic test_backpressure();
        int ex, n, l;
        l = $urandom_range(0, 25);
        ex = m_encrypt(l);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1; in_letter = 5'(l);
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || int'(out_letter) !== ex) begin
                fails++;
                $display("FAIL bp_hold_%0d: valid=%b letter=%0d want 1/%0d",
                         c, out_valid, out_letter, ex);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_in_ready_%0d: got %b want 0", c, in_ready);
            end
            checks++;
            if (int'(dut.pos[0]) !== mpos[0] || int'(dut.pos[1]) !== mpos[1]
                || int'(dut.pos[2]) !== mpos[2]) begin
                fails++; $display("FAIL bp_pos_%0d: positions moved", c);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int got, lat, ex, n;
        apply_reset();
        ex = m_encrypt(0);
        encrypt(0, 0, got, lat);
        checks++;
        if (got !== ex) begin
            fails++; $display("FAIL mid_first: got %0d want %0d", got, ex);
        end
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1; in_letter = 5'd4;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_ctl: valid=%b busy=%b ready=%b want 0/0/0",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (int'(dut.pos[0]) !== 0 || int'(dut.pos[1]) !== 0
            || int'(dut.pos[2]) !== 0) begin
            fails++;
            $display("FAIL mid_rst_pos: got %0d/%0d/%0d want 0/0/0",
                     dut.pos[2], dut.pos[1], dut.pos[0]);
        end
        checks++;
        if (int'(dut.typ[0]) !== 2 || int'(dut.typ[1]) !== 1
            || int'(dut.typ[2]) !== 0) begin
            fails++;
            $display("FAIL mid_rst_typ: got %0d/%0d/%0d want 0/1/2",
                     dut.typ[2], dut.typ[1], dut.typ[0]);
        end
        rst = 0;
        m_reset();
        encrypt(0, 0, got, lat);
        ex = m_encrypt(0);
        checks++;
        if (got !== 1 || lat !== 8) begin
            fails++;
            $display("FAIL mid_reencrypt: got %0d lat %0d want 1 lat 8", got, lat);
        end
    endtask

    task automatic test_config();
        int got, lat, ex, n;
        apply_reset();
        cfg_we = 1; cfg_idx = 0; cfg_type = 4; cfg_pos = 5;
        in_valid = 1; in_letter = 5'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL cfg_vs_input_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        cfg_we = 0; in_valid = 0;
        mpos[0] = 5; mtyp[0] = 4;
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL cfg_vs_input_busy: got %b want 0", busy);
        end
        checks++;
        if (int'(dut.pos[0]) !== 5 || int'(dut.typ[0]) !== 4) begin
            fails++;
            $display("FAIL cfg_applied: pos %0d typ %0d want 5/4",
                     dut.pos[0], dut.typ[0]);
        end
        ex = m_encrypt(7);
        in_valid = 1; in_letter = 5'd7;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        cfg_we = 1; cfg_idx = 1; cfg_type = 3; cfg_pos = 7;
        @(posedge clk); #1;
        cfg_we = 0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (int'(out_letter) !== ex) begin
            fails++; $display("FAIL cfg_busy_ct: got %0d want %0d", out_letter, ex);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (int'(dut.pos[1]) !== mpos[1] || int'(dut.typ[1]) !== mtyp[1]) begin
            fails++;
            $display("FAIL cfg_busy_drop: pos %0d typ %0d want %0d/%0d",
                     dut.pos[1], dut.typ[1], mpos[1], mtyp[1]);
        end
        do_cfg(2, 0, 27);
        checks++;
        if (int'(dut.pos[2]) !== mpos[2]) begin
            fails++; $display("FAIL cfg_pos27: got %0d want %0d", dut.pos[2], mpos[2]);
        end
        do_cfg(0, 6, 3);
        checks++;
        if (int'(dut.typ[0]) !== mtyp[0] || int'(dut.pos[0]) !== mpos[0]) begin
            fails++;
            $display("FAIL cfg_type6: typ %0d pos %0d want %0d/%0d",
                     dut.typ[0], dut.pos[0], mtyp[0], mpos[0]);
        end
        do_cfg(5, 1, 1);
        ex = m_encrypt(11);
        encrypt(11, 0, got, lat);
        checks++;
        if (got !== ex) begin
            fails++; $display("FAIL cfg_after_ct: got %0d want %0d", got, ex);
        end
    endtask

    task automatic test_passthrough();
        int got, lat, ex;
        ex = m_encrypt(30);
        encrypt(30, 0, got, lat);
        checks++;
        if (got !== 30 || lat !== 8) begin
            fails++;
            $display("FAIL passthru: got %0d lat %0d want %0d lat 8", got, lat, ex);
        end
        checks++;
        if (int'(dut.pos[0]) !== mpos[0] || int'(dut.pos[1]) !== mpos[1]
            || int'(dut.pos[2]) !== mpos[2]) begin
            fails++; $display("FAIL passthru_pos: positions moved");
        end
    endtask

    task automatic test_random();
        int got, lat, ex, l;
        apply_reset();
        for (int i = 0; i < N; i++)
            do_cfg(i, $urandom_range(0, 4), $urandom_range(0, 25));
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 15) == 0)
                do_cfg($urandom_range(0, N - 1), $urandom_range(0, 4),
                       $urandom_range(0, 25));
            if ($urandom_range(0, 9) == 0) l = $urandom_range(26, 31);
            else                           l = $urandom_range(0, 25);
            ex = m_encrypt(l);
            encrypt(l, $urandom_range(0, 3), got, lat);
            checks++;
            if (got !== ex || lat !== 8) begin
                fails++;
                $display("FAIL rand_%0d: in %0d got %0d lat %0d want %0d lat 8",
                         t, l, got, lat, ex);
            end
        end
    endtask

    initial begin
        WIR = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                "BDFHJLCPRTXVZNYEIWGAKMUSQO",
                "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                "VZBRGITYUPSDNHLXAWMJQOFECK"};
        REFB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
        MNOTCH = '{16, 4, 21, 9, 25};
        test_reset();
        test_known_vector();
        test_double_step();
        test_backpressure();
        test_reset_mid();
        test_config();
        test_passthrough();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_pipe.md
Name: enigma_rotor_pipe

Overview:
- Parametrised, multi-cycle Enigma scrambler core. It is the next generation of the fixed 3-rotor `top` datapath.
- Supports `NUM_ROTORS` runtime-configurable rotors (types I–V) with reflector B and classic double-step stepping.
- Uses valid/ready handshakes on both letter ports.
- One shared rotor-mapping unit is time-multiplexed: one rotor pass per cycle, forward, then reflector, then backward. This trades latency for area on a Tiny Tapeout tile.

Parameters:
- NUM_ROTORS, 3, number of rotors. Index 0 is the rightmost/fastest. Range 2..6.
- LW, 5, letter width in bits.
- ALPHA, 26, alphabet size. Letters 0..25 map to A..Z.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input letter valid.
- in_ready  out  1  core idle and able to accept a letter.
- in_letter  in  LW  plaintext letter.
- out_valid  out  1  ciphertext valid; held until accepted.
- out_ready  in  1  downstream accepts the ciphertext.
- out_letter  out  LW  ciphertext letter.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  3  rotor index being written.
- cfg_type  in  3  rotor type, 0..4 = I..V.
- cfg_pos  in  LW  rotor start position, 0..25.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock, `clk`; reset is synchronous, active-high, named `rst`, sampled on the rising edge of `clk`.
- Reset values:
  - in_ready=0 during reset, 1 on the first cycle after reset.
  - out_valid=0, out_letter=0, busy=0.
  - All positions = 0.
  - Types: rotor0=III, rotor1=II, rotor2=I, rotors≥3=I.
- Reset asserted mid-operation aborts the letter, returns to IDLE and restores all reset values.
- FSM states: IDLE, STEP, FWD, REFL, BWD, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_letter and go to STEP.
  - STEP (1 cycle): update all rotor positions, then go to FWD.
  - FWD (NUM_ROTORS cycles): rotor counter k runs 0→N-1.
  - REFL (1 cycle).
  - BWD (NUM_ROTORS cycles): k runs N-1→0.
  - OUT: out_valid=1; out_letter held stable until out_valid&&out_ready, then return to IDLE.
- Latency: out_valid rises 2N+2 clock edges after the accepting edge (8 for N=3).
  - in_ready stays 0 from acceptance until the cycle after the output handshake.
  - Minimum period: 2N+4 cycles per letter with out_ready held high.
- Stepping, evaluated on pre-step positions p[], all updates simultaneous:
  - Rotor 0 always steps.
  - Rotor i (i≥1) steps if rotor i-1 is at its notch.
  - Rotor i with 1≤i≤N-2 additionally steps if it is itself at its notch (double step).
  - Notch positions: I=Q(16), II=E(4), III=V(21), IV=J(9), V=Z(25).
  - Positions wrap 25→0.
- Mapping per rotor pass, all arithmetic mod 26:
  - Forward: c'=(W[(c+p)]−p).
  - Backward: uses the inverse table.
  - Reflector: c'=B[c].
  - Modular add/sub uses a 6-bit intermediate with a conditional ±26 correction. No `%` operator.
- Letters ≥26: accepted and passed through unchanged with the same latency; no rotor steps.
- Configuration writes:
  - Honoured only in IDLE with no simultaneous input acceptance. If cfg_we and the input handshake coincide, the config write wins and in_ready is forced 0 that cycle.
  - Writes while busy are dropped.
  - Writes with cfg_idx≥NUM_ROTORS, cfg_type>4 or cfg_pos≥26 are ignored entirely.

Decomposition:
- Package `enigma_pkg`:
  - ALPHA constant and rotor_type_t enum (I..V).
  - Forward and inverse wiring tables for I–V.
  - Reflector B table and notch array.
  - mod26 add/sub functions.
- Sub-module `enigma_rotor_map`: combinational; inputs letter, pos, type, dir (fwd/bwd); output letter. Instantiated once and time-shared by the FSM.

Test Plan:
- Rotors I-II-III (left→right), pos AAA; input AAAAA → out BDZGO; each output arrives 8 cycles after acceptance.
- Pos A-D-U, input 3 letters; positions after each step are ADV, AEW, BFX (double step of the middle rotor).
- Hold out_ready=0 for 5 cycles after out_valid → out_letter stable, in_ready=0, no position change; then out_ready=1 → one handshake, in_ready=1 the next cycle.
- Assert rst during FWD of the 2nd letter → next cycle out_valid=0, positions 000, types III/II/I; re-encrypting A from AAA gives B.
- cfg_we with in_valid in IDLE → config applied, letter not accepted. cfg_we while busy → ignored. cfg_pos=27 → ignored.
- in_letter=30 → out_letter=30 after 8 cycles, positions unchanged.
